// File: rtl/sync_fifo_lvl.sv
// sync_fifo_lvl: synchronous FIFO with level, almost-full/empty thresholds, flush and sticky error flags
module sync_fifo_lvl #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AFULL_TH   = DEPTH - 1,
  parameter int AEMPTY_TH  = 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       wr_en_i,
  input  logic [DATA_WIDTH-1:0]      wr_data_i,
  output logic                       full_o,
  output logic                       almost_full_o,
  input  logic                       rd_en_i,
  output logic [DATA_WIDTH-1:0]      rd_data_o,
  output logic                       empty_o,
  output logic                       not_empty_o,
  output logic                       almost_empty_o,
  output logic [$clog2(DEPTH):0]     level_o,
  output logic                       overflow_o,
  output logic                       underflow_o,
  input  logic                       err_clr_i
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic wr_acc, rd_acc, ovf_set, udf_set;
  always_comb begin
    level_o        = wr_ptr - rd_ptr;
    empty_o        = wr_ptr == rd_ptr;
    not_empty_o    = !empty_o;
    full_o         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    almost_full_o  = level_o >= PW'(AFULL_TH);
    almost_empty_o = level_o <= PW'(AEMPTY_TH);
    rd_data_o      = mem[rd_ptr[AW-1:0]];
    // a read frees the head slot this edge, so a full FIFO can still take a write
    wr_acc         = wr_en_i && (!full_o || rd_en_i) && !flush_i;
    rd_acc         = rd_en_i && !empty_o && !flush_i;
    ovf_set        = wr_en_i && full_o && !rd_en_i && !flush_i;
    udf_set        = rd_en_i && empty_o && !flush_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_ptr      <= flush_i ? '0 : wr_ptr + PW'(wr_acc);
      rd_ptr      <= flush_i ? '0 : rd_ptr + PW'(rd_acc);
      overflow_o  <= ovf_set || (overflow_o && !err_clr_i);
      underflow_o <= udf_set || (underflow_o && !err_clr_i);
      if (wr_acc) mem[wr_ptr[AW-1:0]] <= wr_data_i;
    end
  end
endmodule

// File: tb/tb_sync_fifo_lvl.sv
// tb_sync_fifo_lvl: directed and randomized checks of sync_fifo_lvl against a queue-based model
module tb_sync_fifo_lvl;
  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int AFT   = 6;
  localparam int AET   = 1;
  logic clk = 0, rst_n = 0, flush = 0, wr = 0, rd = 0, clr = 0;
  logic [DW-1:0] wdata = '0;
  logic full, afull, empty, nempty, aempty, ovf, udf;
  logic [DW-1:0] rdata;
  logic [3:0] level;
  int errors = 0, checks = 0;
  logic [DW-1:0] q[$];
  bit m_ovf, m_udf;
  sync_fifo_lvl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .AFULL_TH(AFT), .AEMPTY_TH(AET)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush), .wr_en_i(wr), .wr_data_i(wdata),
    .full_o(full), .almost_full_o(afull), .rd_en_i(rd), .rd_data_o(rdata),
    .empty_o(empty), .not_empty_o(nempty), .almost_empty_o(aempty), .level_o(level),
    .overflow_o(ovf), .underflow_o(udf), .err_clr_i(clr)
  );
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end
  task automatic tick();
    bit f, e;
    @(posedge clk);
    if (!rst_n) begin
      q.delete(); m_ovf = 0; m_udf = 0;
    end else if (flush) begin
      q.delete(); m_ovf = m_ovf && !clr; m_udf = m_udf && !clr;
    end else begin
      f = q.size() == DEPTH; e = q.size() == 0;
      m_ovf = (wr && f && !rd) || (m_ovf && !clr);
      m_udf = (rd && e) || (m_udf && !clr);
      if (rd && !e) void'(q.pop_front());
      if (wr && (!f || rd)) q.push_back(wdata);
    end
    #1;
  endtask
  task automatic idle();
    wr = 0; rd = 0; flush = 0; clr = 0;
  endtask
  task automatic test_reset();
    idle(); rst_n = 0;
    tick(); tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (nempty !== 1'b0) begin errors++; $display("FAIL reset_not_empty got %b exp 0", nempty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL reset_level got %0d exp 0", level); end
    checks++; if (aempty !== 1'b1 || afull !== 1'b0) begin errors++; $display("FAIL reset_almost got ae=%b af=%b exp ae=1 af=0", aempty, afull); end
    checks++; if (rdata !== 8'h00) begin errors++; $display("FAIL reset_rdata got %h exp 00", rdata); end
    checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL reset_flags got ovf=%b udf=%b exp 0 0", ovf, udf); end
    rst_n = 1;
    tick();
  endtask
  task automatic test_fill_drain();
    for (int i = 1; i <= DEPTH; i++) begin
      idle(); wr = 1; wdata = DW'(i);
      tick();
      checks++; if (level !== 4'(i)) begin errors++; $display("FAIL fill_level got %0d exp %0d", level, i); end
      checks++; if (afull !== (i >= AFT)) begin errors++; $display("FAIL fill_afull at %0d got %b exp %b", i, afull, i >= AFT); end
      checks++; if (full !== (i == DEPTH)) begin errors++; $display("FAIL fill_full at %0d got %b exp %b", i, full, i == DEPTH); end
    end
    for (int i = 1; i <= DEPTH; i++) begin
      idle(); rd = 1;
      checks++; if (rdata !== DW'(i)) begin errors++; $display("FAIL drain_data got %h exp %h", rdata, DW'(i)); end
      tick();
    end
    idle();
    checks++; if (empty !== 1'b1 || level !== 4'd0) begin errors++; $display("FAIL drain_empty got e=%b l=%0d exp 1 0", empty, level); end
  endtask
  task automatic test_full_rw();
    for (int i = 1; i <= DEPTH; i++) begin idle(); wr = 1; wdata = DW'(i); tick(); end
    idle(); wr = 1; rd = 1; wdata = 8'hAA;
    checks++; if (rdata !== 8'h01) begin errors++; $display("FAIL full_rw_head got %h exp 01", rdata); end
    tick(); idle();
    checks++; if (level !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL full_rw_level got %0d full=%b exp 8 1", level, full); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL full_rw_ovf got %b exp 0", ovf); end
    for (int i = 2; i <= DEPTH + 1; i++) begin
      idle(); rd = 1;
      checks++; if (rdata !== ((i == DEPTH + 1) ? 8'hAA : DW'(i))) begin errors++; $display("FAIL full_rw_drain got %h exp %h", rdata, (i == DEPTH + 1) ? 8'hAA : DW'(i)); end
      tick();
    end
    idle();
  endtask
  task automatic test_wrap();
    for (int i = 0; i < 20; i++) begin
      idle(); wr = 1; wdata = DW'($urandom); rd = q.size() >= 3;
      if (rd) begin
        checks++; if (rdata !== q[0]) begin errors++; $display("FAIL wrap_data got %h exp %h", rdata, q[0]); end
      end
      tick();
      checks++; if (level !== 4'(q.size()) || level > 4'd8) begin errors++; $display("FAIL wrap_level got %0d exp %0d", level, q.size()); end
    end
    while (q.size() > 0) begin
      idle(); rd = 1;
      checks++; if (rdata !== q[0]) begin errors++; $display("FAIL wrap_drain got %h exp %h", rdata, q[0]); end
      tick();
    end
    idle();
  endtask
  task automatic test_errors();
    for (int i = 1; i <= DEPTH; i++) begin idle(); wr = 1; wdata = DW'(8'h10 + i); tick(); end
    idle(); wr = 1; wdata = 8'h55; tick(); idle();
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got %b exp 1", ovf); end
    checks++; if (level !== 4'd8) begin errors++; $display("FAIL ovf_level got %0d exp 8", level); end
    for (int i = 1; i <= DEPTH; i++) begin
      idle(); rd = 1;
      checks++; if (rdata !== DW'(8'h10 + i)) begin errors++; $display("FAIL ovf_contents got %h exp %h", rdata, DW'(8'h10 + i)); end
      tick();
    end
    idle(); rd = 1; tick(); idle();
    checks++; if (udf !== 1'b1 || level !== 4'd0) begin errors++; $display("FAIL udf_set got %b l=%0d exp 1 0", udf, level); end
    rd = 1; clr = 1; tick(); idle();
    checks++; if (udf !== 1'b1 || ovf !== 1'b0) begin errors++; $display("FAIL set_over_clr got udf=%b ovf=%b exp 1 0", udf, ovf); end
    clr = 1; tick(); idle();
    checks++; if (udf !== 1'b0 || ovf !== 1'b0) begin errors++; $display("FAIL err_clr got udf=%b ovf=%b exp 0 0", udf, ovf); end
  endtask
  task automatic test_flush();
    for (int i = 1; i <= 5; i++) begin idle(); wr = 1; wdata = DW'(8'h20 + i); tick(); end
    idle(); flush = 1; wr = 1; wdata = 8'hEE; tick(); idle();
    checks++; if (level !== 4'd0 || empty !== 1'b1) begin errors++; $display("FAIL flush_level got %0d e=%b exp 0 1", level, empty); end
    checks++; if (ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL flush_flags got %b %b exp 0 0", ovf, udf); end
    tick();
    checks++; if (level !== 4'd0) begin errors++; $display("FAIL flush_write_ignored got %0d exp 0", level); end
  endtask
  task automatic test_async_reset();
    for (int i = 1; i <= 3; i++) begin idle(); wr = 1; wdata = DW'(8'h30 + i); tick(); end
    idle(); rd = 1; tick(); idle();
    #2 rst_n = 0; q.delete(); m_ovf = 0; m_udf = 0;
    #1;
    checks++; if (empty !== 1'b1 || nempty !== 1'b0 || full !== 1'b0 || level !== 4'd0) begin errors++; $display("FAIL arst_status got e=%b ne=%b f=%b l=%0d exp 1 0 0 0", empty, nempty, full, level); end
    checks++; if (aempty !== 1'b1 || afull !== 1'b0 || rdata !== 8'h00 || ovf !== 1'b0 || udf !== 1'b0) begin errors++; $display("FAIL arst_misc got ae=%b af=%b d=%h o=%b u=%b exp 1 0 00 0 0", aempty, afull, rdata, ovf, udf); end
    tick(); rst_n = 1; tick();
  endtask
  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      wr = $urandom_range(0, 9) < 6; rd = $urandom_range(0, 9) < 5;
      flush = $urandom_range(0, 19) == 0; clr = $urandom_range(0, 14) == 0;
      wdata = DW'($urandom);
      tick();
      checks++; if (level !== 4'(q.size())) begin errors++; $display("FAIL rand_level got %0d exp %0d", level, q.size()); end
      checks++; if (full !== (q.size() == DEPTH) || empty !== (q.size() == 0) || nempty !== (q.size() != 0)) begin errors++; $display("FAIL rand_fe got f=%b e=%b ne=%b size %0d", full, empty, nempty, q.size()); end
      checks++; if (afull !== (q.size() >= AFT) || aempty !== (q.size() <= AET)) begin errors++; $display("FAIL rand_almost got af=%b ae=%b size %0d", afull, aempty, q.size()); end
      checks++; if (ovf !== m_ovf || udf !== m_udf) begin errors++; $display("FAIL rand_flags got o=%b u=%b exp %b %b", ovf, udf, m_ovf, m_udf); end
      if (q.size() > 0) begin
        checks++; if (rdata !== q[0]) begin errors++; $display("FAIL rand_data got %h exp %h", rdata, q[0]); end
      end
    end
    idle();
  endtask
  initial begin
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_wrap();
    test_errors();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
